// File: rtl/cpu_decode_stage_pkg.sv
// Shared RV32I decode constants: major opcodes, ALU funct3 operations and funct7 modifiers.
// Also holds the helper that checks a funct7 modifier against its funct3.
package cpu_decode_stage_pkg;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    localparam logic [2:0] INST_ARLOG_ADD = 3'b000;
    localparam logic [2:0] INST_ARLOG_SLL = 3'b001;
    localparam logic [2:0] INST_ARLOG_SR  = 3'b101;

    // MOD_ALT selects SUB for ADD and arithmetic shift for SR.
    localparam logic [6:0] ALU_MOD_ADD = 7'h00;
    localparam logic [6:0] ALU_MOD_ALT = 7'h20;

    // ADD/SUB and SRL/SRA accept either modifier; every other operation needs the plain one.
    function automatic logic mod_legal(input logic [2:0] funct3, input logic [6:0] funct7);
        if (funct3 == INST_ARLOG_ADD || funct3 == INST_ARLOG_SR)
            return (funct7 == ALU_MOD_ADD) || (funct7 == ALU_MOD_ALT);
        else
            return funct7 == ALU_MOD_ADD;
    endfunction

endpackage

// File: rtl/cpu_imm_gen.sv
// Combinational extraction of the I-type (sign-extended) and U-type immediates.
// Only instruction bits [31:12] carry immediate data for these two formats.
module cpu_imm_gen (
    input  logic [19:0] inst_upper,
    output logic [31:0] imm_i,
    output logic [31:0] imm_u
);

    assign imm_i = {{20{inst_upper[19]}}, inst_upper[19:8]};
    assign imm_u = {inst_upper, 12'b0};

endmodule

// File: rtl/cpu_decode_stage.sv
// Registered RV32I decode stage for OP, OP-IMM, LUI and AUIPC; anything else is flagged illegal.
// Single output register with a valid/ready handshake on both sides and no skid buffer.
module cpu_decode_stage
    import cpu_decode_stage_pkg::*;
#(
    parameter int                XLEN     = 32,
    parameter logic [XLEN-1:0]   RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_inst,
    input  logic [XLEN-1:0] in_pc,
    output logic [4:0]      rs1_addr,
    output logic [4:0]      rs2_addr,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [2:0]      out_operation,
    output logic [6:0]      out_mod,
    output logic [XLEN-1:0] out_operand_a,
    output logic [XLEN-1:0] out_operand_b,
    output logic [4:0]      out_rd,
    output logic            out_rd_write,
    output logic [XLEN-1:0] out_pc,
    output logic            out_illegal
);

    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [4:0]      rd;
    logic [31:0]     imm_i;
    logic [31:0]     imm_u;
    logic [XLEN-1:0] rs1_val;
    logic [XLEN-1:0] rs2_val;

    logic            dec_legal;
    logic [2:0]      dec_op;
    logic [6:0]      dec_mod;
    logic [XLEN-1:0] dec_a;
    logic [XLEN-1:0] dec_b;
    logic            accept;

    assign opcode   = in_inst[6:0];
    assign rd       = in_inst[11:7];
    assign funct3   = in_inst[14:12];
    assign rs1_addr = in_inst[19:15];
    assign rs2_addr = in_inst[24:20];
    assign funct7   = in_inst[31:25];

    // x0 always reads as zero regardless of what the register file returns.
    assign rs1_val = (rs1_addr == 5'd0) ? '0 : rs1_data;
    assign rs2_val = (rs2_addr == 5'd0) ? '0 : rs2_data;

    cpu_imm_gen u_imm_gen (
        .inst_upper (in_inst[31:12]),
        .imm_i      (imm_i),
        .imm_u      (imm_u)
    );

    // NOTE: every combinational output gets a default first so no path through the case infers a latch.
    always_comb begin
        dec_legal = 1'b0;
        dec_op    = INST_ARLOG_ADD;
        dec_mod   = ALU_MOD_ADD;
        dec_a     = '0;
        dec_b     = '0;
        unique case (opcode)
            OPC_OP: begin
                dec_legal = mod_legal(funct3, funct7);
                dec_op    = funct3;
                dec_mod   = funct7;
                dec_a     = rs1_val;
                dec_b     = rs2_val;
            end
            OPC_OP_IMM: begin
                dec_op = funct3;
                dec_a  = rs1_val;
                dec_b  = imm_i;
                // Only the shifts use imm[11:5] as a modifier; the shift amount stays unmasked in B.
                if (funct3 == INST_ARLOG_SLL || funct3 == INST_ARLOG_SR) begin
                    dec_legal = mod_legal(funct3, funct7);
                    dec_mod   = funct7;
                end else begin
                    dec_legal = 1'b1;
                end
            end
            OPC_LUI: begin
                dec_legal = 1'b1;
                dec_b     = imm_u;
            end
            OPC_AUIPC: begin
                dec_legal = 1'b1;
                dec_a     = in_pc;
                dec_b     = imm_u;
            end
            default: ;
        endcase
        if (!dec_legal) begin
            dec_op  = '0;
            dec_mod = '0;
            dec_a   = '0;
            dec_b   = '0;
        end
    end

    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid     <= 1'b0;
            out_illegal   <= 1'b0;
            out_rd_write  <= 1'b0;
            out_operation <= '0;
            out_mod       <= '0;
            out_operand_a <= '0;
            out_operand_b <= '0;
            out_rd        <= '0;
            out_pc        <= RESET_PC;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (accept) begin
            out_valid     <= 1'b1;
            out_illegal   <= !dec_legal;
            out_rd_write  <= dec_legal && (rd != 5'd0);
            out_operation <= dec_op;
            out_mod       <= dec_mod;
            out_operand_a <= dec_a;
            out_operand_b <= dec_b;
            out_rd        <= rd;
            out_pc        <= in_pc;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_cpu_decode_stage.sv
// Directed bench for cpu_decode_stage: hand-computed decode results, stall, flush and reset cases.
// A small register file drives rs1_data/rs2_data combinationally from the read addresses.
module tb_cpu_decode_stage;

    localparam logic [31:0] RST_PC = 32'h0000_0080;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_inst;
    logic [31:0] in_pc;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic        out_valid;
    logic        out_ready;
    logic [2:0]  out_operation;
    logic [6:0]  out_mod;
    logic [31:0] out_operand_a;
    logic [31:0] out_operand_b;
    logic [4:0]  out_rd;
    logic        out_rd_write;
    logic [31:0] out_pc;
    logic        out_illegal;

    logic [31:0] regs [0:31];
    int          errors = 0;
    int          checks = 0;

    cpu_decode_stage #(.XLEN(32), .RESET_PC(RST_PC)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .flush         (flush),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_inst       (in_inst),
        .in_pc         (in_pc),
        .rs1_addr      (rs1_addr),
        .rs2_addr      (rs2_addr),
        .rs1_data      (rs1_data),
        .rs2_data      (rs2_data),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_operation (out_operation),
        .out_mod       (out_mod),
        .out_operand_a (out_operand_a),
        .out_operand_b (out_operand_b),
        .out_rd        (out_rd),
        .out_rd_write  (out_rd_write),
        .out_pc        (out_pc),
        .out_illegal   (out_illegal)
    );

    assign rs1_data = regs[rs1_addr];
    assign rs2_data = regs[rs2_addr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_bundle(input string tag, input logic [2:0] op, input logic [6:0] md,
                                input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd,
                                input logic wr, input logic ill, input logic [31:0] pc);
        check({tag, ".valid"}, {31'd0, out_valid}, 32'd1);
        check({tag, ".op"}, {29'd0, out_operation}, {29'd0, op});
        check({tag, ".mod"}, {25'd0, out_mod}, {25'd0, md});
        check({tag, ".a"}, out_operand_a, a);
        check({tag, ".b"}, out_operand_b, b);
        if (!ill) check({tag, ".rd"}, {27'd0, out_rd}, {27'd0, rd});
        check({tag, ".wr"}, {31'd0, out_rd_write}, {31'd0, wr});
        check({tag, ".ill"}, {31'd0, out_illegal}, {31'd0, ill});
        check({tag, ".pc"}, out_pc, pc);
    endtask

    task automatic present(input logic [31:0] inst, input logic [31:0] pc);
        in_valid = 1'b1;
        in_inst  = inst;
        in_pc    = pc;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) regs[i] = 32'hDEAD_BEEF;
        regs[1] = 32'd5;
        regs[2] = 32'd7;
        regs[6] = 32'h8000_0000;

        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_inst = '0; in_pc = '0; out_ready = 1'b1;
        tick(); tick();

        // Reset values
        check("rst.valid", {31'd0, out_valid}, 32'd0);
        check("rst.ill", {31'd0, out_illegal}, 32'd0);
        check("rst.wr", {31'd0, out_rd_write}, 32'd0);
        check("rst.op", {29'd0, out_operation}, 32'd0);
        check("rst.mod", {25'd0, out_mod}, 32'd0);
        check("rst.a", out_operand_a, 32'd0);
        check("rst.b", out_operand_b, 32'd0);
        check("rst.rd", {27'd0, out_rd}, 32'd0);
        check("rst.pc", out_pc, RST_PC);
        check("rst.in_ready", {31'd0, in_ready}, 32'd1);
        rst_n = 1'b1;
        tick();

        // ADD x3,x1,x2
        present(32'h0020_81B3, 32'h100);
        #1;
        check("add.rs1_addr", {27'd0, rs1_addr}, 32'd1);
        check("add.rs2_addr", {27'd0, rs2_addr}, 32'd2);
        tick();
        check_bundle("add", 3'b000, 7'h00, 32'd5, 32'd7, 5'd3, 1'b1, 1'b0, 32'h100);

        // SUB x3,x1,x2
        present(32'h4020_81B3, 32'h104);
        tick();
        check_bundle("sub", 3'b000, 7'h20, 32'd5, 32'd7, 5'd3, 1'b1, 1'b0, 32'h104);

        // OP with funct7=0x01 is illegal here
        present(32'h0220_81B3, 32'h108);
        tick();
        check_bundle("op_f7_01", 3'b000, 7'h00, 32'd0, 32'd0, 5'd3, 1'b0, 1'b1, 32'h108);

        // ADDI x1,x0,-1 : x0 reads zero even though regs[0] is nonzero
        present(32'hFFF0_0093, 32'h10C);
        tick();
        check_bundle("addi", 3'b000, 7'h00, 32'd0, 32'hFFFF_FFFF, 5'd1, 1'b1, 1'b0, 32'h10C);

        // SRAI x5,x6,3 : B keeps the full imm 0x403
        present(32'h4033_5293, 32'h110);
        tick();
        check_bundle("srai", 3'b101, 7'h20, 32'h8000_0000, 32'h403, 5'd5, 1'b1, 1'b0, 32'h110);

        // SLLI x1,x1,3
        present(32'h0030_9093, 32'h114);
        tick();
        check_bundle("slli", 3'b001, 7'h00, 32'd5, 32'd3, 5'd1, 1'b1, 1'b0, 32'h114);

        // SLLI with imm[11:5]=0x20 is illegal
        present(32'h4010_9093, 32'h118);
        tick();
        check_bundle("slli_bad", 3'b000, 7'h00, 32'd0, 32'd0, 5'd1, 1'b0, 1'b1, 32'h118);

        // Low bits 2'b00 -> illegal
        present(32'h0000_0000, 32'h11C);
        tick();
        check_bundle("opc_bad", 3'b000, 7'h00, 32'd0, 32'd0, 5'd0, 1'b0, 1'b1, 32'h11C);

        // AUIPC x2,0x12345 at pc 0x100
        present(32'h1234_5117, 32'h100);
        tick();
        check_bundle("auipc", 3'b000, 7'h00, 32'h100, 32'h1234_5000, 5'd2, 1'b1, 1'b0, 32'h100);

        // Stall: LUI waits while execute holds the AUIPC bundle
        out_ready = 1'b0;
        present(32'hABCD_E3B7, 32'h200);
        #1;
        check("stall.in_ready", {31'd0, in_ready}, 32'd0);
        for (int i = 0; i < 5; i++) begin
            tick();
            check_bundle("stall", 3'b000, 7'h00, 32'h100, 32'h1234_5000, 5'd2, 1'b1, 1'b0, 32'h100);
        end

        // Release: consume and accept in the same cycle
        out_ready = 1'b1;
        #1;
        check("release.in_ready", {31'd0, in_ready}, 32'd1);
        tick();
        check_bundle("lui", 3'b000, 7'h00, 32'd0, 32'hABCD_E000, 5'd7, 1'b1, 1'b0, 32'h200);

        // Flush beats both the held bundle and the incoming instruction
        present(32'h0020_81B3, 32'h300);
        flush = 1'b1;
        #1;
        check("flush.in_ready", {31'd0, in_ready}, 32'd1);
        tick();
        check("flush.valid", {31'd0, out_valid}, 32'd0);
        flush = 1'b0;
        in_valid = 1'b0;
        tick();
        check("flush.idle", {31'd0, out_valid}, 32'd0);

        // Flush while the bundle is stalled
        present(32'h0020_81B3, 32'h304);
        tick();
        check("load2.valid", {31'd0, out_valid}, 32'd1);
        in_valid = 1'b0;
        out_ready = 1'b0;
        flush = 1'b1;
        tick();
        check("flush_held.valid", {31'd0, out_valid}, 32'd0);
        flush = 1'b0;
        out_ready = 1'b1;

        // Consume without a new accept empties the stage
        present(32'h4020_81B3, 32'h308);
        tick();
        check("load3.valid", {31'd0, out_valid}, 32'd1);
        in_valid = 1'b0;
        tick();
        check("drain.valid", {31'd0, out_valid}, 32'd0);

        // Asynchronous reset mid-stream
        present(32'h0020_81B3, 32'h400);
        tick();
        check("load4.valid", {31'd0, out_valid}, 32'd1);
        present(32'h4033_5293, 32'h404);
        #2;
        rst_n = 1'b0;
        #1;
        check("mrst.valid", {31'd0, out_valid}, 32'd0);
        check("mrst.wr", {31'd0, out_rd_write}, 32'd0);
        check("mrst.a", out_operand_a, 32'd0);
        check("mrst.b", out_operand_b, 32'd0);
        check("mrst.rd", {27'd0, out_rd}, 32'd0);
        check("mrst.pc", out_pc, RST_PC);
        tick();
        check("mrst.hold", {31'd0, out_valid}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
